// File: rtl/unidade_busca.sv
// ----------------------------------------------------------------------------
// unidade_busca -- fetch-stage program counter
//
// Produces one word address per cycle for the instruction memory, follows
// BNE redirects from execute, holds on stall requests, and stops once the
// loaded program is exhausted or a branch lands outside it.
//
// Parameters:
//   PROG_LEN    number of instruction words loaded (valid addresses 0..PROG_LEN-1)
//   PC_INICIAL  first fetch address after reset (must be < PROG_LEN)
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous, active-high reset
//   pausa           stall request: hold the current address
//   desvio          single-cycle branch-taken pulse
//   pc_desvio       address of the branching instruction
//   desvio_offset   signed branch offset in words
//   endereco        registered fetch address
//   endereco_valido endereco is a live fetch this cycle
//   fim             program ran past its last word (sticky)
//   erro            branch target out of range (sticky)
//   estado          FSM state, for debug
//   contador_instr  accepted-fetch count, saturating; present only when
//                   BUSCA_CONTADOR_EN is defined
// ----------------------------------------------------------------------------
module unidade_busca #(
  parameter int unsigned PROG_LEN   = 3,
  parameter int unsigned PC_INICIAL = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pausa,
  input  logic        desvio,
  input  logic [31:0] pc_desvio,
  input  logic [11:0] desvio_offset,
  output logic [31:0] endereco,
  output logic        endereco_valido,
  output logic        fim,
  output logic        erro,
  output logic [1:0]  estado
`ifdef BUSCA_CONTADOR_EN
  ,
  output logic [31:0] contador_instr
`endif
);

  typedef enum logic [1:0] {
    INICIO  = 2'b00,
    BUSCA   = 2'b01,
    PAUSADO = 2'b10,
    FIM     = 2'b11
  } estado_t;

  localparam logic [31:0] LIMITE  = 32'(PROG_LEN);
  localparam logic [31:0] ULTIMO  = 32'(PROG_LEN - 1);
  localparam logic [31:0] PC_ZERO = 32'(PC_INICIAL);

  estado_t     estado_q, estado_d;
  logic [31:0] endereco_d;
  logic        valido_d;
  logic        fim_d;
  logic        erro_d;

  // Branch target wraps mod 2^32, so a negative result is a huge unsigned
  // value and fails the single unsigned range compare.
  logic [31:0] alvo;
  logic        alvo_ok;

  assign alvo    = pc_desvio + {{20{desvio_offset[11]}}, desvio_offset};
  assign alvo_ok = (alvo < LIMITE);
  assign estado  = estado_q;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco;
    valido_d   = endereco_valido;
    fim_d      = fim;
    erro_d     = erro;

    unique case (estado_q)
      INICIO: begin
        estado_d = BUSCA;
        valido_d = 1'b1;
      end

      BUSCA, PAUSADO: begin
        if (desvio) begin
          // Branch outranks stall; a legal redirect may still land in PAUSADO.
          if (alvo_ok) begin
            endereco_d = alvo;
            estado_d   = pausa ? PAUSADO : BUSCA;
            valido_d   = !pausa;
          end else begin
            estado_d = FIM;
            erro_d   = 1'b1;
            valido_d = 1'b0;
          end
        end else if (pausa) begin
          estado_d = PAUSADO;
          valido_d = 1'b0;
        end else if (estado_q == PAUSADO) begin
          // Leaving a stall replays the held address instead of advancing.
          estado_d = BUSCA;
          valido_d = 1'b1;
        end else if (endereco == ULTIMO) begin
          estado_d = FIM;
          fim_d    = 1'b1;
          valido_d = 1'b0;
        end else begin
          endereco_d = endereco + 32'd1;
          valido_d   = 1'b1;
        end
      end

      FIM: begin
        // Frozen until reset: defaults already hold everything.
      end

      default: estado_d = INICIO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q        <= INICIO;
      endereco        <= PC_ZERO;
      endereco_valido <= 1'b0;
      fim             <= 1'b0;
      erro            <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      endereco        <= endereco_d;
      endereco_valido <= valido_d;
      fim             <= fim_d;
      erro            <= erro_d;
    end
  end

`ifdef BUSCA_CONTADOR_EN
  // An accepted fetch is a valid address in BUSCA that is neither stalled
  // nor discarded by a redirect on this edge.
  logic aceita;
  assign aceita = (estado_q == BUSCA) && endereco_valido && !pausa && !desvio;

  always_ff @(posedge clock) begin
    if (reset) begin
      contador_instr <= 32'd0;
    end else if (aceita && (contador_instr != 32'hFFFF_FFFF)) begin
      contador_instr <= contador_instr + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// ----------------------------------------------------------------------------
// tb_unidade_busca -- self-checking bench for unidade_busca (PROG_LEN=3,
// PC_INICIAL=0). A table of per-edge stimulus and expected outputs is played
// back, followed by a bounded free-run sequence up to end of program.
// ----------------------------------------------------------------------------
module tb_unidade_busca;

  localparam logic [1:0] S_INICIO  = 2'b00;
  localparam logic [1:0] S_BUSCA   = 2'b01;
  localparam logic [1:0] S_PAUSADO = 2'b10;
  localparam logic [1:0] S_FIM     = 2'b11;

  logic        clock;
  logic        reset;
  logic        pausa;
  logic        desvio;
  logic [31:0] pc_desvio;
  logic [11:0] desvio_offset;
  logic [31:0] endereco;
  logic        endereco_valido;
  logic        fim;
  logic        erro;
  logic [1:0]  estado;
`ifdef BUSCA_CONTADOR_EN
  logic [31:0] contador_instr;
`endif

  int total = 0;
  int bad   = 0;

  unidade_busca #(.PROG_LEN(3), .PC_INICIAL(0)) dut (
    .clock           (clock),
    .reset           (reset),
    .pausa           (pausa),
    .desvio          (desvio),
    .pc_desvio       (pc_desvio),
    .desvio_offset   (desvio_offset),
    .endereco        (endereco),
    .endereco_valido (endereco_valido),
    .fim             (fim),
    .erro            (erro),
    .estado          (estado)
`ifdef BUSCA_CONTADOR_EN
    ,
    .contador_instr  (contador_instr)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        pa;
    logic        de;
    logic [31:0] pc;
    logic [11:0] off;
    logic [31:0] e_end;
    logic        e_val;
    logic        e_fim;
    logic        e_err;
    logic [1:0]  e_est;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic d,
                       input logic [31:0] pc, input logic [11:0] off);
    @(negedge clock);
    reset         = r;
    pausa         = p;
    desvio        = d;
    pc_desvio     = pc;
    desvio_offset = off;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic r, input logic p, input logic d, input logic [31:0] pc,
                     input logic [11:0] off, input logic [31:0] ee, input logic ev,
                     input logic ef, input logic er, input logic [1:0] es, input logic [31:0] ec);
    vec_t v;
    v.rst = r;  v.pa = p;  v.de = d;  v.pc = pc;  v.off = off;
    v.e_end = ee; v.e_val = ev; v.e_fim = ef; v.e_err = er; v.e_est = es; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  initial begin
    int n_valid;
    int cycles;
    logic [31:0] exp_addr;
    string tag;

    reset = 1'b1; pausa = 1'b0; desvio = 1'b0; pc_desvio = '0; desvio_offset = '0;

    //   rst pa de  pc  off      end val fim err estado     cnt
    add(1, 0, 0, 0, 12'h000,   0, 0, 0, 0, S_INICIO,  0);  // 0 reset state
    add(0, 0, 0, 0, 12'h000,   0, 1, 0, 0, S_BUSCA,   0);  // 1 first valid
    add(0, 0, 0, 0, 12'h000,   1, 1, 0, 0, S_BUSCA,   1);
    add(0, 0, 0, 0, 12'h000,   2, 1, 0, 0, S_BUSCA,   2);
    add(0, 0, 0, 0, 12'h000,   2, 0, 1, 0, S_FIM,     3);  // 4 end of program
    add(0, 1, 1, 0, 12'h000,   2, 0, 1, 0, S_FIM,     3);  // 5 FIM ignores inputs
    add(1, 0, 0, 0, 12'h000,   0, 0, 0, 0, S_INICIO,  0);  // 6 reset from FIM
    add(0, 0, 0, 0, 12'h000,   0, 1, 0, 0, S_BUSCA,   0);
    add(0, 0, 0, 0, 12'h000,   1, 1, 0, 0, S_BUSCA,   1);
    add(0, 1, 0, 0, 12'h000,   1, 0, 0, 0, S_PAUSADO, 1);  // 9 stall at 1
    add(0, 1, 0, 0, 12'h000,   1, 0, 0, 0, S_PAUSADO, 1);
    add(0, 0, 0, 0, 12'h000,   1, 1, 0, 0, S_BUSCA,   1);  // 11 replay 1
    add(0, 0, 0, 0, 12'h000,   2, 1, 0, 0, S_BUSCA,   2);
    add(0, 0, 1, 2, 12'hFFE,   0, 1, 0, 0, S_BUSCA,   2);  // 13 2 + (-2) = 0
    add(0, 0, 0, 0, 12'h000,   1, 1, 0, 0, S_BUSCA,   3);
    add(0, 1, 1, 1, 12'hFFF,   0, 0, 0, 0, S_PAUSADO, 3);  // 15 branch + stall
    add(0, 0, 0, 0, 12'h000,   0, 1, 0, 0, S_BUSCA,   3);  // 16 fetch 0
    add(0, 1, 0, 0, 12'h000,   0, 0, 0, 0, S_PAUSADO, 3);
    add(0, 1, 1, 0, 12'h002,   2, 0, 0, 0, S_PAUSADO, 3);  // 18 redirect while stalled
    add(1, 0, 0, 0, 12'h000,   0, 0, 0, 0, S_INICIO,  0);  // 19 reset from PAUSADO
    add(0, 0, 0, 0, 12'h000,   0, 1, 0, 0, S_BUSCA,   0);
    add(0, 0, 1, 1, 12'h005,   0, 0, 0, 1, S_FIM,     0);  // 21 target 6 illegal
    add(0, 1, 1, 0, 12'h000,   0, 0, 0, 1, S_FIM,     0);
    add(0, 0, 0, 0, 12'h000,   0, 0, 0, 1, S_FIM,     0);
    add(1, 0, 0, 0, 12'h000,   0, 0, 0, 0, S_INICIO,  0);
    add(0, 0, 0, 0, 12'h000,   0, 1, 0, 0, S_BUSCA,   0);
    add(0, 0, 0, 0, 12'h000,   1, 1, 0, 0, S_BUSCA,   1);
    add(0, 0, 1, 0, 12'hFFF,   1, 0, 0, 1, S_FIM,     1);  // 27 0-1 wraps: illegal
    add(1, 0, 0, 0, 12'h000,   0, 0, 0, 0, S_INICIO,  0);
    add(0, 0, 0, 0, 12'h000,   0, 1, 0, 0, S_BUSCA,   0);
    add(0, 1, 0, 0, 12'h000,   0, 0, 0, 0, S_PAUSADO, 0);
    add(0, 0, 1, 0, 12'h800,   0, 0, 0, 1, S_FIM,     0);  // 31 illegal from PAUSADO
    add(1, 0, 0, 0, 12'h000,   0, 0, 0, 0, S_INICIO,  0);
    add(0, 0, 0, 0, 12'h000,   0, 1, 0, 0, S_BUSCA,   0);
    add(0, 0, 1, 0, 12'h002,   2, 1, 0, 0, S_BUSCA,   0);  // 34 target = last word
    add(0, 0, 0, 0, 12'h000,   2, 0, 1, 0, S_FIM,     1);
    add(1, 0, 0, 0, 12'h000,   0, 0, 0, 0, S_INICIO,  0);
    add(0, 0, 0, 0, 12'h000,   0, 1, 0, 0, S_BUSCA,   0);
    add(0, 0, 1, 1, 12'h002,   0, 0, 0, 1, S_FIM,     0);  // 38 target = PROG_LEN

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].pa, tbl[i].de, tbl[i].pc, tbl[i].off);
      tag = $sformatf("v%0d", i);
      check({tag, ".endereco"}, endereco,        tbl[i].e_end);
      check({tag, ".valido"},   endereco_valido, tbl[i].e_val);
      check({tag, ".fim"},      fim,             tbl[i].e_fim);
      check({tag, ".erro"},     erro,            tbl[i].e_err);
      check({tag, ".estado"},   estado,          tbl[i].e_est);
`ifdef BUSCA_CONTADOR_EN
      check({tag, ".contador"}, contador_instr,  tbl[i].e_cnt);
`endif
    end

    // Free run from reset: expect exactly words 0,1,2 in order, then fim,
    // with a cycle budget in case the block never stops.
    drive(1, 0, 0, 0, 12'h000);
    n_valid  = 0;
    cycles   = 0;
    exp_addr = 0;
    while (!fim && cycles < 10) begin
      drive(0, 0, 0, 0, 12'h000);
      cycles++;
      if (endereco_valido) begin
        check($sformatf("run.addr%0d", n_valid), endereco, exp_addr);
        exp_addr++;
        n_valid++;
      end
    end
    check("run.terminated", fim, 1'b1);
    check("run.valid_count", n_valid, 3);
    check("run.cycles", cycles, 4);
    check("run.estado", estado, S_FIM);
    check("run.valido_off", endereco_valido, 1'b0);
`ifdef BUSCA_CONTADOR_EN
    check("run.contador", contador_instr, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
